// File: rtl/motion_code_sequencer_pkg.sv
// motion_pkg: motion codes, button patterns, decode and reversal helpers, FSM states
package motion_pkg;

    typedef enum logic [2:0] {
        STOP    = 3'd0,
        FORWARD = 3'd1,
        REVERSE = 3'd2,
        RIGHT1X = 3'd3,
        RIGHT2X = 3'd4,
        LEFT1X  = 3'd5,
        LEFT2X  = 3'd6
    } motion_t;

    typedef enum logic {
        TRACK = 1'b0,
        GUARD = 1'b1
    } state_t;

    // debounced button patterns, ordered {LEFT,UP,RIGHT,DOWN}
    localparam logic [3:0] BTN_NONE   = 4'b0000;
    localparam logic [3:0] BTN_FWD    = 4'b1010;
    localparam logic [3:0] BTN_REV    = 4'b0101;
    localparam logic [3:0] BTN_SPIN_R = 4'b1001;
    localparam logic [3:0] BTN_SPIN_L = 4'b0110;

    function automatic logic is_reversal(motion_t cur, motion_t tgt);
        return (cur == FORWARD && tgt == REVERSE) || (cur == REVERSE && tgt == FORWARD) ||
               (cur == RIGHT2X && tgt == LEFT2X)  || (cur == LEFT2X  && tgt == RIGHT2X);
    endfunction

    // per wheel: forward only, reverse only, or stopped (none or both pressed)
    function automatic motion_t decode(logic [3:0] db);
        logic lf, lr, rf, rr, ls, rs;
        lf = db[3] & ~db[2];
        lr = db[2] & ~db[3];
        rf = db[1] & ~db[0];
        rr = db[0] & ~db[1];
        ls = ~(lf | lr);
        rs = ~(rf | rr);
        return (lf & rf) ? FORWARD :
               (lr & rr) ? REVERSE :
               (lf & rr) ? RIGHT2X :
               (lr & rf) ? LEFT2X  :
               ((lf & rs) | (ls & rr)) ? RIGHT1X :
               ((lr & rs) | (ls & rf)) ? LEFT1X  : STOP;
    endfunction

endpackage

// File: rtl/motion_code_sequencer_if.sv
// motion_code_sequencer_if: motion code valid/ready handshake plus debounced button LEDs
interface motion_code_sequencer_if #(
    parameter int CODE_W = 3
);
    logic [CODE_W-1:0] Code;
    logic              CODE_VALID;
    logic              CODE_READY;
    logic [3:0]        BTN_DB;

    modport master (output Code, CODE_VALID, BTN_DB, input CODE_READY);
    modport slave  (input Code, CODE_VALID, BTN_DB, output CODE_READY);
endinterface

// File: rtl/motion_code_sequencer_btn_debounce.sv
// btn_debounce: single-button debouncer; optional 2-flop synchronizer under BTN_SYNC_EN
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic raw,
    output logic db
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s;
    logic [CW-1:0] cnt;

`ifdef BTN_SYNC_EN
    logic [1:0] sync;

    // bring the asynchronous button into the clock domain
    always_ff @(posedge CLK) begin
        if (!RESET_N) sync <= '0;
        else          sync <= {sync[0], raw};
    end

    assign s = sync[1];
`else
    assign s = raw;
`endif

    // count consecutive mismatching cycles; flip the output once the input has held long enough
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (s != db) begin
            cnt <= (cnt == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt + 1'b1;
            db  <= (cnt == CW'(DEBOUNCE_CYCLES - 1)) ? s : db;
        end else begin
            cnt <= '0;
        end
    end
endmodule

// File: rtl/motion_code_sequencer.sv
// motion_code_sequencer: debounced buttons -> motion code with reversal STOP guard and valid/ready output
// Define BTN_SYNC_EN to add a 2-flop synchronizer on each raw button.
module motion_code_sequencer
    import motion_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int STOP_HOLD_CYCLES = 1000000,
    parameter int CODE_W           = 3
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     BTN_LEFT,
    input  logic                     BTN_UP,
    input  logic                     BTN_RIGHT,
    input  logic                     BTN_DOWN,
    motion_code_sequencer_if.master  bus
);
    localparam int HW = $clog2(STOP_HOLD_CYCLES + 1);

    logic [3:0]    raw, db;
    motion_t       target, code, code_nxt;
    state_t        state, state_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic          valid, rev;

    assign raw = {BTN_LEFT, BTN_UP, BTN_RIGHT, BTN_DOWN};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_db
            btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .CLK    (CLK),
                .RESET_N(RESET_N),
                .raw    (raw[i]),
                .db     (db[i])
            );
        end
    endgenerate

    assign target = decode(db);
    assign rev    = is_reversal(code, target);

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= TRACK;
        else          state <= state_nxt;
    end

    // enter GUARD on a reversal, leave when the hold counter has run out
    always_comb begin
        state_nxt = (state == TRACK) ? (rev ? GUARD : TRACK) : (hold == '0 ? TRACK : GUARD);
    end

    // next code and hold count; GUARD pins STOP and ignores target until the count expires
    always_comb begin
        code_nxt = (state == GUARD) ? (hold == '0 ? target : STOP) : (rev ? STOP : target);
        hold_nxt = (state == GUARD) ? (hold == '0 ? hold : hold - 1'b1)
                                    : (rev ? HW'(STOP_HOLD_CYCLES - 1) : hold);
    end

    // code/hold registers and valid flag; a change always wins over a same-cycle acceptance
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            code  <= STOP;
            hold  <= '0;
            valid <= 1'b0;
        end else begin
            code  <= code_nxt;
            hold  <= hold_nxt;
            valid <= (code_nxt != code) | (valid & ~bus.CODE_READY);
        end
    end

    assign bus.Code       = CODE_W'(code);
    assign bus.CODE_VALID = valid;
    assign bus.BTN_DB     = db;
endmodule

// File: tb/tb_motion_code_sequencer.sv
// tb_motion_code_sequencer: directed vectors and hand sequences for motion_code_sequencer
module tb_motion_code_sequencer;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       ready = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;

    motion_code_sequencer_if #(.CODE_W(3)) bus ();
    assign bus.CODE_READY = ready;

    motion_code_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .STOP_HOLD_CYCLES(8),
        .CODE_W          (3)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .BTN_LEFT (btn[3]),
        .BTN_UP   (btn[2]),
        .BTN_RIGHT(btn[1]),
        .BTN_DOWN (btn[0]),
        .bus      (bus)
    );

    typedef struct {
        logic [3:0] btn;
        logic [2:0] code;
    } vec_t;

    vec_t tbl[16];

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input int code, input int valid, input int db);
        chk({name, " code"}, int'(bus.Code), code);
        chk({name, " valid"}, int'(bus.CODE_VALID), valid);
        chk({name, " db"}, int'(bus.BTN_DB), db);
    endtask

    initial begin
        tbl[0]  = '{4'b0000, 3'd0};
        tbl[1]  = '{4'b1000, 3'd3};
        tbl[2]  = '{4'b0100, 3'd5};
        tbl[3]  = '{4'b0010, 3'd5};
        tbl[4]  = '{4'b0001, 3'd3};
        tbl[5]  = '{4'b1010, 3'd1};
        tbl[6]  = '{4'b1001, 3'd4};
        tbl[7]  = '{4'b1111, 3'd0};
        tbl[8]  = '{4'b0110, 3'd6};
        tbl[9]  = '{4'b0101, 3'd2};
        tbl[10] = '{4'b1100, 3'd0};
        tbl[11] = '{4'b1110, 3'd5};
        tbl[12] = '{4'b1011, 3'd3};
        tbl[13] = '{4'b0111, 3'd5};
        tbl[14] = '{4'b0011, 3'd0};
        tbl[15] = '{4'b1101, 3'd3};

        // reset with all buttons pressed
        RESET_N = 1'b0;
        btn = 4'b1111;
        step(3);
        chk_all("reset", 0, 0, 0);
        RESET_N = 1'b1;
        btn = 4'b0000;
        step(1);

        // bouncing LEFT never settles
        for (int k = 0; k < 20; k++) begin
            btn[3] = k[1];
            step(1);
            chk("bounce db", int'(bus.BTN_DB), 0);
            chk("bounce valid", int'(bus.CODE_VALID), 0);
        end
        btn = 4'b0000;
        step(2);

        // forward after debounce latency, then accept
        btn = 4'b1010;
        step(3);
        chk_all("fwd pre", 0, 0, 0);
        step(1);
        chk_all("fwd db", 0, 0, 4'b1010);
        step(1);
        chk_all("fwd code", 1, 1, 4'b1010);
        ready = 1'b1;
        step(1);
        chk_all("fwd accept", 1, 0, 4'b1010);
        ready = 1'b0;

        // reversal inserts 8 cycles of STOP
        btn = 4'b0101;
        step(5);
        chk_all("rev stop", 0, 1, 4'b0101);
        ready = 1'b1;
        step(1);
        chk_all("rev accept", 0, 0, 4'b0101);
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk("rev hold", int'(bus.Code), 0);
        end
        step(1);
        chk_all("rev code", 2, 1, 4'b0101);

        // backpressure: latest code wins, coincident change keeps valid
        btn = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("bp valid a", int'(bus.CODE_VALID), 1);
        end
        chk("bp code a", int'(bus.Code), 3);
        btn = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("bp valid b", int'(bus.CODE_VALID), 1);
        end
        chk("bp code hold", int'(bus.Code), 3);
        ready = 1'b1;
        step(1);
        chk_all("bp coincident", 5, 1, 4'b0100);
        step(1);
        chk_all("bp accept", 5, 0, 4'b0100);
        ready = 1'b0;

        // reset in the middle of a GUARD hold
        btn = 4'b1010;
        step(5);
        chk("g fwd", int'(bus.Code), 1);
        btn = 4'b0101;
        step(5);
        chk_all("g enter", 0, 1, 4'b0101);
        step(2);
        RESET_N = 1'b0;
        step(1);
        chk_all("g reset", 0, 0, 0);
        RESET_N = 1'b1;
        step(3);
        chk_all("g deb pre", 0, 0, 0);
        step(1);
        chk_all("g deb", 0, 0, 4'b0101);
        step(1);
        chk_all("g no hold", 2, 1, 4'b0101);

        // decode table over every button pattern
        RESET_N = 1'b0;
        btn = 4'b0000;
        ready = 1'b1;
        step(2);
        RESET_N = 1'b1;
        for (int k = 0; k < 16; k++) begin
            btn = tbl[k].btn;
            step(8);
            chk_all($sformatf("tbl%0d", k), int'(tbl[k].code), 0, int'(tbl[k].btn));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
